// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_state_e;
  typedef enum logic {MEM_RD, MEM_WR} mem_op_e;

  localparam logic [31:0] FAULT_DATA      = 32'hDEAD_BEEF;
  localparam int unsigned MAX_WAIT_STATES = 15;

endpackage

// File: rtl/mem_array.sv
// Word-addressed single-port 32-bit RAM with registered read.
module mem_array #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Read-before-write: a same-edge read returns the old word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures CPU requests, inserts wait states, acks for one cycle.
// Optional bounds checking with mem_fault output when MEM_RESPONDER_BOUNDS_EN is defined.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_data_oe,
  output logic        mem_ack,
`ifdef MEM_RESPONDER_BOUNDS_EN
  output logic        mem_fault,
`endif
  output logic        busy
);

  localparam int unsigned CntW = $clog2(MAX_WAIT_STATES + 1);

  mem_state_e            state_q, state_d;
  mem_op_e               op_q, op_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [31:0]           rd_hold_q, rd_hold_d;
  logic                  flt_q, flt_d;

  logic                  req_one;
  logic                  addr_oob;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_rdata;
  logic [31:0]           rd_data_resp;

  assign req_one = mem_rd ^ mem_wr;

`ifdef MEM_RESPONDER_BOUNDS_EN
  logic illegal_q;

  assign addr_oob = |addr[31:ADDR_WIDTH];

  // Both-high request is flagged one cycle later while the FSM is still idle.
  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= (state_q == IDLE) && mem_rd && mem_wr;
  end

  assign mem_fault = illegal_q || (mem_ack && flt_q);
`else
  logic unused_addr_hi;

  // Upper address bits alias onto the implemented RAM.
  assign unused_addr_hi = |addr[31:ADDR_WIDTH];
  assign addr_oob       = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    flt_d     = flt_q;
    rd_hold_d = rd_hold_q;

    unique case (state_q)
      IDLE: begin
        if (req_one) begin
          op_d      = mem_wr ? MEM_WR : MEM_RD;
          addr_d    = addr[ADDR_WIDTH-1:0];
          wr_data_d = wr_data;
          flt_d     = addr_oob;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CntW'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        if (op_q == MEM_RD) rd_hold_d = rd_data_resp;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= MEM_RD;
      cnt_q     <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      flt_q     <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      flt_q     <= flt_d;
      rd_hold_q <= rd_hold_d;
    end
  end

  // In IDLE the live address feeds the RAM so a zero-wait read is ready on RESP entry.
  assign ram_addr = (state_q == IDLE) ? addr[ADDR_WIDTH-1:0] : addr_q;
  assign ram_we   = (state_q == RESP) && (op_q == MEM_WR) && !flt_q && !rst;

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_mem_array (
    .clk_i  (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(wr_data_q),
    .rdata_o(ram_rdata)
  );

  assign rd_data_resp = flt_q ? FAULT_DATA : ram_rdata;
  assign mem_ack      = (state_q == RESP);
  assign busy         = (state_q != IDLE);
  assign rd_data_oe   = mem_ack && (op_q == MEM_RD);
  assign rd_data      = rd_data_oe ? rd_data_resp : rd_hold_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench: three responders (1, 0 and 3 wait states) against an array model.
module tb_mem_responder;

  localparam int NDut = 3;
  localparam int unsigned WS0 = 1;
  localparam int unsigned WS1 = 0;
  localparam int unsigned WS2 = 3;

  logic        clk;
  logic        rst    [NDut];
  logic        rd     [NDut];
  logic        wr     [NDut];
  logic [31:0] addr   [NDut];
  logic [31:0] wd     [NDut];
  logic [31:0] rdata  [NDut];
  logic        oe     [NDut];
  logic        ack    [NDut];
  logic        busy   [NDut];
`ifdef MEM_RESPONDER_BOUNDS_EN
  logic        fault  [NDut];
`endif

  logic [31:0] model_mem [NDut][1024];
  logic [31:0] last_rd   [NDut];
  int          n_cmp;
  int          n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS0), .INIT_FILE("")) u_dut0 (
    .clk(clk), .rst(rst[0]), .mem_rd(rd[0]), .mem_wr(wr[0]), .addr(addr[0]),
    .wr_data(wd[0]), .rd_data(rdata[0]), .rd_data_oe(oe[0]), .mem_ack(ack[0]),
`ifdef MEM_RESPONDER_BOUNDS_EN
    .mem_fault(fault[0]),
`endif
    .busy(busy[0])
  );

  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS1), .INIT_FILE("")) u_dut1 (
    .clk(clk), .rst(rst[1]), .mem_rd(rd[1]), .mem_wr(wr[1]), .addr(addr[1]),
    .wr_data(wd[1]), .rd_data(rdata[1]), .rd_data_oe(oe[1]), .mem_ack(ack[1]),
`ifdef MEM_RESPONDER_BOUNDS_EN
    .mem_fault(fault[1]),
`endif
    .busy(busy[1])
  );

  mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS2), .INIT_FILE("")) u_dut2 (
    .clk(clk), .rst(rst[2]), .mem_rd(rd[2]), .mem_wr(wr[2]), .addr(addr[2]),
    .wr_data(wd[2]), .rd_data(rdata[2]), .rd_data_oe(oe[2]), .mem_ack(ack[2]),
`ifdef MEM_RESPONDER_BOUNDS_EN
    .mem_fault(fault[2]),
`endif
    .busy(busy[2])
  );

  function automatic int ws_of(input int d);
    case (d)
      0:       return int'(WS0);
      1:       return int'(WS1);
      default: return int'(WS2);
    endcase
  endfunction

  function automatic bit is_oob(input logic [31:0] a);
`ifdef MEM_RESPONDER_BOUNDS_EN
    return a[31:10] != 22'd0;
`else
    return a[31] & 1'b0;
`endif
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input int d, input string what);
    check_eq($sformatf("d%0d_%s_busy", d, what), 32'(busy[d]), 32'd0);
    check_eq($sformatf("d%0d_%s_ack", d, what), 32'(ack[d]), 32'd0);
    check_eq($sformatf("d%0d_%s_oe", d, what), 32'(oe[d]), 32'd0);
    check_eq($sformatf("d%0d_%s_rdata", d, what), rdata[d], last_rd[d]);
`ifdef MEM_RESPONDER_BOUNDS_EN
    check_eq($sformatf("d%0d_%s_fault", d, what), 32'(fault[d]), 32'd0);
`endif
  endtask

  task automatic scramble(input int d);
    rd[d]   = 1'($urandom_range(0, 1));
    wr[d]   = 1'($urandom_range(0, 1));
    addr[d] = $urandom;
    wd[d]   = $urandom;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the idle check.
  task automatic run_txn(input int d, input bit is_wr, input logic [31:0] a,
                         input logic [31:0] wdat);
    int          ws;
    bit          oob;
    logic [31:0] exp_rd;
    ws     = ws_of(d);
    oob    = is_oob(a);
    exp_rd = oob ? 32'hDEAD_BEEF : model_mem[d][a[9:0]];
    rd[d]   = !is_wr;
    wr[d]   = is_wr;
    addr[d] = a;
    wd[d]   = wdat;
    for (int j = 1; j <= ws + 1; j++) begin
      bit resp;
      @(negedge clk);
      resp = (j == ws + 1);
      check_eq($sformatf("d%0d_busy_c%0d", d, j), 32'(busy[d]), 32'd1);
      check_eq($sformatf("d%0d_ack_c%0d", d, j), 32'(ack[d]), 32'(resp));
      check_eq($sformatf("d%0d_oe_c%0d", d, j), 32'(oe[d]), 32'(resp && !is_wr));
      if (resp && !is_wr)
        check_eq($sformatf("d%0d_rdata_a%h", d, a), rdata[d], exp_rd);
`ifdef MEM_RESPONDER_BOUNDS_EN
      check_eq($sformatf("d%0d_fault_c%0d", d, j), 32'(fault[d]), 32'(resp && oob));
`endif
      if (resp) begin
        rd[d] = 1'b0;
        wr[d] = 1'b0;
      end else begin
        scramble(d);
      end
    end
    if (is_wr && !oob) model_mem[d][a[9:0]] = wdat;
    if (!is_wr) last_rd[d] = exp_rd;
    @(negedge clk);
    check_idle(d, "post");
  endtask

  task automatic run_illegal(input int d, input logic [31:0] a);
    rd[d]   = 1'b1;
    wr[d]   = 1'b1;
    addr[d] = a;
    wd[d]   = ~model_mem[d][a[9:0]];
    @(negedge clk);
    check_eq($sformatf("d%0d_illegal_busy", d), 32'(busy[d]), 32'd0);
    check_eq($sformatf("d%0d_illegal_ack", d), 32'(ack[d]), 32'd0);
`ifdef MEM_RESPONDER_BOUNDS_EN
    check_eq($sformatf("d%0d_illegal_fault", d), 32'(fault[d]), 32'd1);
`endif
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    @(negedge clk);
    check_idle(d, "after_illegal");
  endtask

  // Write that is cut short by reset at cycle at_j after capture; the word must not change.
  task automatic run_rst_write(input int d, input logic [31:0] a, input logic [31:0] wdat,
                               input int at_j);
    rd[d]   = 1'b0;
    wr[d]   = 1'b1;
    addr[d] = a;
    wd[d]   = wdat;
    for (int j = 1; j <= at_j; j++) begin
      @(negedge clk);
      rd[d] = 1'b0;
      wr[d] = 1'b0;
      if (j == at_j) rst[d] = 1'b1;
    end
    @(negedge clk);
    rst[d] = 1'b0;
    last_rd[d] = 32'd0;
    check_idle(d, $sformatf("rst_c%0d", at_j));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int d = 0; d < NDut; d++) begin
      rst[d]     = 1'b1;
      rd[d]      = 1'b0;
      wr[d]      = 1'b0;
      addr[d]    = '0;
      wd[d]      = '0;
      last_rd[d] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NDut; d++) check_idle(d, "reset");
    for (int d = 0; d < NDut; d++) rst[d] = 1'b0;

    // Give the low 16 words defined contents before any read.
    for (int d = 0; d < NDut; d++)
      for (int w = 0; w < 16; w++) run_txn(d, 1'b1, 32'(w), $urandom);

    run_txn(0, 1'b1, 32'd5, 32'h1234_5678);
    run_txn(0, 1'b0, 32'd5, 32'h0);
    run_txn(1, 1'b1, 32'd3, 32'hCAFE_F00D);
    run_txn(1, 1'b0, 32'd3, 32'h0);
    run_txn(2, 1'b0, 32'd9, 32'h0);

    run_txn(0, 1'b1, 32'h0000_0400, 32'hA5A5_A5A5);
    run_txn(0, 1'b0, 32'd0, 32'h0);
    run_txn(0, 1'b0, 32'h0000_0400, 32'h0);

    for (int d = 0; d < NDut; d++) begin
      run_illegal(d, 32'd7);
      run_txn(d, 1'b0, 32'd7, 32'h0);
    end

    run_rst_write(2, 32'd11, 32'h5555_AAAA, 1);
    run_txn(2, 1'b0, 32'd11, 32'h0);
    run_rst_write(0, 32'd12, 32'h0F0F_F0F0, 2);
    run_txn(0, 1'b0, 32'd12, 32'h0);
    run_rst_write(1, 32'd13, 32'h7777_1111, 1);
    run_txn(1, 1'b0, 32'd13, 32'h0);

    for (int n = 0; n < 40; n++) begin
      for (int d = 0; d < NDut; d++) begin
        logic [31:0] a;
        a = 32'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) a = a | ($urandom << 10);
        run_txn(d, 1'($urandom_range(0, 1)), a, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
